dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the data memory used by the MEM stage. It shares the single asynchronous data memory between the pipeline MEM stage (port A) and a loader/debug port (port B). It registers each granted access into a one-cycle access slot, captures read data into a response register, and raises a stall to the pipeline while port A is denied. B may lock the memory for multi-access bursts; a starvation guard bounds B's wait while unlocked.

---
 rtl/dmem_arbiter.sv | 82 ++++++++
 tb/tb_dmem_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data memory arbiter with lockable B port, starvation guard and registered access slot
module dmem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_rw,
  input  logic        a_size,
  input  logic [7:0]  a_addr,
  input  logic [31:0] a_wdata,
  input  logic        b_req,
  input  logic        b_rw,
  input  logic        b_size,
  input  logic [7:0]  b_addr,
  input  logic [31:0] b_wdata,
  input  logic        b_lock,
  output logic        a_gnt,
  output logic        b_gnt,
  output logic        a_rvalid,
  output logic        b_rvalid,
  output logic [31:0] a_rdata,
  output logic [31:0] b_rdata,
  output logic        pipe_stall,
  output logic        mem_E,
  output logic        mem_RW,
  output logic        mem_Size,
  output logic [7:0]  mem_A,
  output logic [31:0] mem_DI,
  input  logic [31:0] mem_DO
);
  typedef enum logic {ARB, LOCK_B} state_t;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  state_t state, state_n;
  logic [3:0] streak;
  logic b_win, slot_v, slot_b, slot_rw, slot_size, rd_a, rd_b;
  logic [7:0] slot_addr;
  logic [31:0] slot_wdata;
  always_comb begin
    b_win = b_req & (~a_req | (streak == SMAX));
    b_gnt = (state == LOCK_B) ? b_req : b_win;
    a_gnt = (state == ARB) & a_req & ~b_win;
    state_n = (state == ARB) ? ((b_gnt & b_lock) ? LOCK_B : ARB) : (b_lock ? LOCK_B : ARB);
  end
  assign pipe_stall = a_req & ~a_gnt;
  assign mem_E      = slot_v;
  assign mem_RW     = slot_v & slot_rw;
  assign mem_Size   = slot_v & slot_size;
  assign mem_A      = slot_v ? slot_addr : 8'd0;
  assign mem_DI     = slot_v ? slot_wdata : 32'd0;
  assign rd_a       = slot_v & ~slot_rw & ~slot_b;
  assign rd_b       = slot_v & ~slot_rw & slot_b;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ARB;
      streak     <= 4'd0;
      slot_v     <= 1'b0;
      slot_b     <= 1'b0;
      slot_rw    <= 1'b0;
      slot_size  <= 1'b0;
      slot_addr  <= 8'd0;
      slot_wdata <= 32'd0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      a_rdata    <= 32'd0;
      b_rdata    <= 32'd0;
    end else begin
      state      <= state_n;
      streak     <= (b_gnt | ~b_req) ? 4'd0 : (a_gnt && streak != SMAX) ? streak + 4'd1 : streak;
      slot_v     <= a_gnt | b_gnt;
      slot_b     <= b_gnt;
      slot_rw    <= b_gnt ? b_rw : a_rw;
      slot_size  <= b_gnt ? b_size : a_size;
      slot_addr  <= b_gnt ? b_addr : a_addr;
      slot_wdata <= b_gnt ? b_wdata : a_wdata;
      a_rvalid   <= rd_a;
      b_rvalid   <= rd_b;
      if (rd_a) a_rdata <= mem_DO;
      if (rd_b) b_rdata <= mem_DO;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of arbitration, lock, starvation, latency and reset
module tb_dmem_arbiter;
  logic clk = 0, reset = 0;
  logic a_req = 0, a_rw = 0, a_size = 0, b_req = 0, b_rw = 0, b_size = 0, b_lock = 0;
  logic [7:0] a_addr = 0, b_addr = 0, mem_A;
  logic [31:0] a_wdata = 0, b_wdata = 0, a_rdata, b_rdata, mem_DI, mem_DO;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, pipe_stall, mem_E, mem_RW, mem_Size;
  logic [7:0] mem [256];
  int checks = 0, errors = 0;

  dmem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_rw(a_rw), .a_size(a_size), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_rw(b_rw), .b_size(b_size), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .pipe_stall(pipe_stall),
    .mem_E(mem_E), .mem_RW(mem_RW), .mem_Size(mem_Size), .mem_A(mem_A), .mem_DI(mem_DI), .mem_DO(mem_DO)
  );

  always #5 clk = ~clk;

  assign mem_DO = mem_Size ? {mem[mem_A + 8'd3], mem[mem_A + 8'd2], mem[mem_A + 8'd1], mem[mem_A]}
                           : {24'd0, mem[mem_A]};

  always @(posedge clk)
    if (mem_E & mem_RW) begin
      mem[mem_A] <= mem_DI[7:0];
      if (mem_Size) begin
        mem[mem_A + 8'd1] <= mem_DI[15:8];
        mem[mem_A + 8'd2] <= mem_DI[23:16];
        mem[mem_A + 8'd3] <= mem_DI[31:24];
      end
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic seta(input logic req, input logic rw, input logic sz, input logic [7:0] ad, input logic [31:0] wd);
    a_req = req; a_rw = rw; a_size = sz; a_addr = ad; a_wdata = wd;
  endtask

  task automatic setb(input logic req, input logic rw, input logic sz, input logic [7:0] ad, input logic [31:0] wd, input logic lk);
    b_req = req; b_rw = rw; b_size = sz; b_addr = ad; b_wdata = wd; b_lock = lk;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    seta(0, 0, 0, 0, 0);
    setb(0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
    mem[8'h10] <= 8'h44; mem[8'h11] <= 8'h33; mem[8'h12] <= 8'h22; mem[8'h13] <= 8'h11;
    repeat (2) tick();
    #1;
    chk("rst_mem_E", {31'd0, mem_E}, 0);
    chk("rst_mem_A", {24'd0, mem_A}, 0);
    chk("rst_mem_DI", mem_DI, 0);
    chk("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_gnt", {30'd0, a_gnt, b_gnt}, 0);
    reset = 1;

    tick(); seta(1, 0, 1, 8'h10, 0); #1;
    chk("rd_c1_gnt", {30'd0, a_gnt, b_gnt}, 2);
    chk("rd_c1_stall", {31'd0, pipe_stall}, 0);
    chk("rd_c1_memE", {31'd0, mem_E}, 0);
    tick(); seta(0, 0, 0, 0, 0); #1;
    chk("rd_c2_memE", {31'd0, mem_E}, 1);
    chk("rd_c2_memA", {24'd0, mem_A}, 32'h10);
    chk("rd_c2_ctl", {30'd0, mem_RW, mem_Size}, 1);
    chk("rd_c2_rvalid", {31'd0, a_rvalid}, 0);
    tick(); #1;
    chk("rd_c3_rvalid", {31'd0, a_rvalid}, 1);
    chk("rd_c3_rdata", a_rdata, 32'h11223344);
    chk("rd_c3_memE", {31'd0, mem_E}, 0);
    tick(); #1;
    chk("rd_c4_rvalid", {31'd0, a_rvalid}, 0);
    chk("rd_c4_hold", a_rdata, 32'h11223344);
    idle(2);

    for (int i = 1; i <= 6; i++) begin
      tick(); seta(1, 0, 1, 8'h10, 0); setb(1, 0, 1, 8'h10, 0, 0); #1;
      chk($sformatf("starve_c%0d_gnt", i), {30'd0, a_gnt, b_gnt}, (i == 5) ? 32'd1 : 32'd2);
      chk($sformatf("starve_c%0d_stall", i), {31'd0, pipe_stall}, (i == 5) ? 32'd1 : 32'd0);
    end
    idle(3);

    for (int i = 1; i <= 8; i++) begin
      tick();
      seta(1, 0, 1, 8'h10, 0);
      setb(i <= 7, 1, 1, 8'h40, 32'hDEADBEEF, i <= 6);
      #1;
      chk($sformatf("lock_c%0d_gnt", i), {30'd0, a_gnt, b_gnt},
          (i < 5 || i == 8) ? 32'd2 : (i <= 7) ? 32'd1 : 32'd0);
      chk($sformatf("lock_c%0d_stall", i), {31'd0, pipe_stall}, (i >= 5 && i <= 7) ? 32'd1 : 32'd0);
      if (i == 6) begin
        chk("lock_c6_mem", {mem_E, mem_RW, mem_Size, 21'd0, mem_A}, {3'b111, 21'd0, 8'h40});
        chk("lock_c6_DI", mem_DI, 32'hDEADBEEF);
      end
    end
    idle(3);
    chk("lock_mem_word", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'hDEADBEEF);

    tick(); seta(1, 1, 0, 8'h20, 32'h000000AB); #1;
    chk("b2b_c1_gnt", {31'd0, a_gnt}, 1);
    tick(); seta(1, 0, 0, 8'h20, 0); #1;
    chk("b2b_c2_gnt", {31'd0, a_gnt}, 1);
    chk("b2b_c2_mem", {mem_E, mem_RW, mem_Size, 21'd0, mem_A}, {3'b110, 21'd0, 8'h20});
    chk("b2b_c2_DI", mem_DI, 32'h000000AB);
    tick(); seta(0, 0, 0, 0, 0); #1;
    chk("b2b_c3_mem", {mem_E, mem_RW, 22'd0, mem_A}, {2'b10, 22'd0, 8'h20});
    chk("b2b_c3_rvalid", {31'd0, a_rvalid}, 0);
    tick(); #1;
    chk("b2b_c4_rvalid", {31'd0, a_rvalid}, 1);
    chk("b2b_c4_rdata", {24'd0, a_rdata[7:0]}, 32'hAB);
    idle(2);

    tick(); setb(1, 0, 1, 8'h10, 0, 0); #1;
    chk("rst_mid_c1_gnt", {30'd0, a_gnt, b_gnt}, 1);
    reset = 0;
    tick(); reset = 1; setb(0, 0, 0, 0, 0, 0); seta(1, 0, 1, 8'h10, 0); #1;
    chk("rst_mid_c2_memE", {31'd0, mem_E}, 0);
    chk("rst_mid_c2_rvalid", {31'd0, b_rvalid}, 0);
    chk("rst_mid_c2_rdata", b_rdata, 0);
    chk("rst_mid_c2_gnt", {30'd0, a_gnt, b_gnt}, 2);
    tick(); seta(0, 0, 0, 0, 0); #1;
    chk("rst_mid_c3_rvalid", {31'd0, b_rvalid}, 0);
    chk("rst_mid_c3_memE", {31'd0, mem_E}, 1);
    tick(); #1;
    chk("rst_mid_c4_arvalid", {31'd0, a_rvalid}, 1);
    idle(2);

    tick(); setb(1, 0, 1, 8'h10, 0, 1); #1;
    chk("idle_c1_gnt", {30'd0, a_gnt, b_gnt}, 1);
    tick(); setb(0, 0, 0, 0, 0, 0); seta(1, 0, 1, 8'h10, 0); #1;
    chk("idle_c2_gnt", {30'd0, a_gnt, b_gnt}, 0);
    chk("idle_c2_stall", {31'd0, pipe_stall}, 1);
    tick(); #1;
    chk("idle_c3_gnt", {30'd0, a_gnt, b_gnt}, 2);
    tick(); seta(0, 0, 0, 0, 0); setb(0, 0, 0, 0, 0, 1); #1;
    chk("nolock_c1_gnt", {30'd0, a_gnt, b_gnt}, 0);
    tick(); seta(1, 0, 1, 8'h10, 0); b_lock = 0; #1;
    chk("nolock_c2_gnt", {30'd0, a_gnt, b_gnt}, 2);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
